pll_mode_sequencer: RTL and testbench

Sequencing controller for the HDMI pixel/serial clock PLLVR. Drives the PLL's RESET and dynamic divider selects (IDSEL/FBDSEL/ODSEL), qualifies LOCK, and releases the video pipeline reset only after a stable lock. It accepts run-time mode-change requests from the video-mode register, retries failed locks, and reports a hard failure. Runs on the 27 MHz board oscillator, upstream of the PLL.

---
 rtl/pll_mode_sequencer_if.sv | 28 ++
 rtl/pll_mode_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pll_mode_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_mode_sequencer_if.sv
// Mode-change request bus between the video-mode register and the PLL sequencer.
//   req_valid  : requester has new select codes
//   req_ready  : sequencer can accept a request (RUN or FAIL only)
//   req_idsel, req_fbdsel, req_odsel : raw PLLVR dynamic select codes
// master = video-mode register side, slave = sequencer side.
interface pll_mode_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_idsel;
  logic [5:0] req_fbdsel;
  logic [5:0] req_odsel;

  modport master (
    output req_valid,
    output req_idsel,
    output req_fbdsel,
    output req_odsel,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_idsel,
    input  req_fbdsel,
    input  req_odsel,
    output req_ready
  );
endinterface

// File: rtl/pll_mode_sequencer.sv
// Sequencing controller for the HDMI PLLVR: holds the PLL in reset while new
// divider selects settle, waits for and qualifies LOCK, then releases the video
// pipeline reset. Retries on lock timeout or lock loss, reports hard failure.
// Ports:
//   clk, resetn        : 27 MHz reference, async active-low reset
//   req                : mode-change request bus (slave modport)
//   pll_lock           : PLL LOCK, asynchronous to clk
//   pll_reset          : PLL RESET
//   pll_idsel/fbdsel/odsel : PLL dynamic divider selects
//   locked             : qualified lock
//   video_resetn       : active-low reset for the HDMI pipeline
//   busy               : reconfiguration in progress
//   err                : sticky failure flag, cleared by an accepted request
//   retry_cnt          : retries used for the current configuration
module pll_mode_sequencer #(
  parameter int unsigned RESET_CYCLES        = 32,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter logic [5:0]  BOOT_IDSEL          = 6'h3F,
  parameter logic [5:0]  BOOT_FBDSEL         = 6'h36,
  parameter logic [5:0]  BOOT_ODSEL          = 6'h3C
) (
  input  logic                 clk,
  input  logic                 resetn,
  pll_mode_sequencer_if.slave  req,
  input  logic                 pll_lock,
  output logic                 pll_reset,
  output logic [5:0]           pll_idsel,
  output logic [5:0]           pll_fbdsel,
  output logic [5:0]           pll_odsel,
  output logic                 locked,
  output logic                 video_resetn,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           retry_cnt
);

  localparam int unsigned RST_CW = (RESET_CYCLES > 1)        ? $clog2(RESET_CYCLES)        : 1;
  localparam int unsigned TO_CW  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int unsigned ST_CW  = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;

  localparam logic [RST_CW-1:0] RST_LAST = RST_CW'(RESET_CYCLES - 1);
  localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [ST_CW-1:0]  ST_LAST  = ST_CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRIES);

  localparam logic [2:0] S_APPLY     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [RST_CW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_CW-1:0]  to_cnt_q, to_cnt_d;
  logic [ST_CW-1:0]  st_cnt_q, st_cnt_d;
  logic [1:0]        retry_q, retry_d;
  logic              err_q, err_d;
  logic [5:0]        idsel_q, idsel_d;
  logic [5:0]        fbdsel_q, fbdsel_d;
  logic [5:0]        odsel_q, odsel_d;
  logic              pll_reset_q, pll_reset_d;
  logic              locked_q, locked_d;
  logic              video_resetn_q, video_resetn_d;
  logic              busy_q, busy_d;
  logic              req_ready_q, req_ready_d;
  logic              lk_meta_q, lk_q;
  logic              accept_c;
  logic              retry_take_c;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= pll_lock;
      lk_q      <= lk_meta_q;
    end
  end

  // Next-state, counters and registered-output next values
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = '0;
    to_cnt_d     = '0;
    st_cnt_d     = '0;
    retry_d      = retry_q;
    err_d        = err_q;
    idsel_d      = idsel_q;
    fbdsel_d     = fbdsel_q;
    odsel_d      = odsel_q;
    retry_take_c = 1'b0;
    accept_c     = req.req_valid & req_ready_q;

    case (state_q)
      S_APPLY: begin
        if (rst_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        else                       rst_cnt_d = rst_cnt_q + RST_CW'(1);
      end
      S_WAIT_LOCK: begin
        if (lk_q)                    state_d = S_STABLE;
        else if (to_cnt_q == TO_LAST) retry_take_c = 1'b1;
        else                         to_cnt_d = to_cnt_q + TO_CW'(1);
      end
      S_STABLE: begin
        // Any lk drop restarts qualification with a fresh timeout window
        if (!lk_q) begin
          state_d = S_WAIT_LOCK;
        end else if (st_cnt_q == ST_LAST) begin
          state_d = S_RUN;
          retry_d = 2'd0;
        end else begin
          st_cnt_d = st_cnt_q + ST_CW'(1);
        end
      end
      S_RUN: begin
        if (!lk_q) retry_take_c = 1'b1;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: state_d = S_APPLY;
    endcase

    if (retry_take_c) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 2'd1;
        state_d = S_APPLY;
      end else begin
        state_d = S_FAIL;
        err_d   = 1'b1;
      end
    end

    // Accepted request overrides a same-cycle lock loss
    if (accept_c) begin
      state_d  = S_APPLY;
      retry_d  = 2'd0;
      err_d    = 1'b0;
      idsel_d  = req.req_idsel;
      fbdsel_d = req.req_fbdsel;
      odsel_d  = req.req_odsel;
    end

    pll_reset_d    = (state_d == S_APPLY) || (state_d == S_FAIL);
    locked_d       = (state_d == S_RUN);
    video_resetn_d = (state_d == S_RUN);
    busy_d         = (state_d == S_APPLY) || (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
    req_ready_d    = (state_d == S_RUN) || (state_d == S_FAIL);
  end

  // State, counters and outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_APPLY;
      rst_cnt_q      <= '0;
      to_cnt_q       <= '0;
      st_cnt_q       <= '0;
      retry_q        <= 2'd0;
      err_q          <= 1'b0;
      idsel_q        <= BOOT_IDSEL;
      fbdsel_q       <= BOOT_FBDSEL;
      odsel_q        <= BOOT_ODSEL;
      pll_reset_q    <= 1'b1;
      locked_q       <= 1'b0;
      video_resetn_q <= 1'b0;
      busy_q         <= 1'b1;
      req_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      to_cnt_q       <= to_cnt_d;
      st_cnt_q       <= st_cnt_d;
      retry_q        <= retry_d;
      err_q          <= err_d;
      idsel_q        <= idsel_d;
      fbdsel_q       <= fbdsel_d;
      odsel_q        <= odsel_d;
      pll_reset_q    <= pll_reset_d;
      locked_q       <= locked_d;
      video_resetn_q <= video_resetn_d;
      busy_q         <= busy_d;
      req_ready_q    <= req_ready_d;
    end
  end

  assign req.req_ready  = req_ready_q;
  assign pll_reset      = pll_reset_q;
  assign pll_idsel      = idsel_q;
  assign pll_fbdsel     = fbdsel_q;
  assign pll_odsel      = odsel_q;
  assign locked         = locked_q;
  assign video_resetn   = video_resetn_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign retry_cnt      = retry_q;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed bench for pll_mode_sequencer with small timing parameters.
module tb_pll_mode_sequencer;

  logic       clk;
  logic       resetn;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       locked, video_resetn, busy, err;
  logic [1:0] retry_cnt;

  pll_mode_sequencer_if req_if ();

  pll_mode_sequencer #(
    .RESET_CYCLES        (4),
    .LOCK_TIMEOUT_CYCLES (64),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req          (req_if),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .pll_idsel    (pll_idsel),
    .pll_fbdsel   (pll_fbdsel),
    .pll_odsel    (pll_odsel),
    .locked       (locked),
    .video_resetn (video_resetn),
    .busy         (busy),
    .err          (err),
    .retry_cnt    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [17:0] BOOT = {6'h3F, 6'h36, 6'h3C};
  localparam logic [17:0] M1   = {6'h3E, 6'h30, 6'h38};
  localparam logic [17:0] M2   = {6'h3D, 6'h31, 6'h39};

  typedef struct packed {
    logic        pll_reset;
    logic        locked;
    logic        video_resetn;
    logic        busy;
    logic        req_ready;
    logic        err;
    logic [1:0]  rc;
    logic [17:0] sel;
  } exp_t;

  typedef struct {
    int          adv;
    logic        lock;
    logic        valid;
    logic [17:0] codes;
    exp_t        exp;
    string       name;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(logic r, logic l, logic v, logic b, logic q, logic e,
                              logic [1:0] rc, logic [17:0] sel);
    exp_t x;
    x.pll_reset    = r;
    x.locked       = l;
    x.video_resetn = v;
    x.busy         = b;
    x.req_ready    = q;
    x.err          = e;
    x.rc           = rc;
    x.sel          = sel;
    return x;
  endfunction

  function automatic exp_t e_apply(logic [1:0] rc, logic [17:0] sel);
    return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rc, sel);
  endfunction
  function automatic exp_t e_wait(logic [1:0] rc, logic [17:0] sel);
    return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rc, sel);
  endfunction
  function automatic exp_t e_run(logic [17:0] sel);
    return mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, sel);
  endfunction
  function automatic exp_t e_fail(logic [1:0] rc, logic [17:0] sel);
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rc, sel);
  endfunction

  function automatic exp_t sample();
    return mk(pll_reset, locked, video_resetn, busy, req_if.req_ready, err, retry_cnt,
              {pll_idsel, pll_fbdsel, pll_odsel});
  endfunction

  task automatic add(input int adv, input logic lock, input logic valid,
                     input logic [17:0] codes, input exp_t exp, input string name);
    vec_t v;
    v.adv   = adv;
    v.lock  = lock;
    v.valid = valid;
    v.codes = codes;
    v.exp   = exp;
    v.name  = name;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input exp_t exp);
    exp_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got rst=%0b lkd=%0b vrn=%0b busy=%0b rdy=%0b err=%0b rc=%0d sel=%h/%h/%h, expected rst=%0b lkd=%0b vrn=%0b busy=%0b rdy=%0b err=%0b rc=%0d sel=%h/%h/%h",
               name, act.pll_reset, act.locked, act.video_resetn, act.busy, act.req_ready,
               act.err, act.rc, act.sel[17:12], act.sel[11:6], act.sel[5:0],
               exp.pll_reset, exp.locked, exp.video_resetn, exp.busy, exp.req_ready,
               exp.err, exp.rc, exp.sel[17:12], exp.sel[11:6], exp.sel[5:0]);
    end
  endtask

  task automatic drive_req(input logic valid, input logic [17:0] codes);
    req_if.req_valid  = valid;
    req_if.req_idsel  = codes[17:12];
    req_if.req_fbdsel = codes[11:6];
    req_if.req_odsel  = codes[5:0];
  endtask

  task automatic do_reset();
    pll_lock = 1'b0;
    drive_req(1'b0, 18'd0);
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  initial begin
    // Comments give the clock edge count since reset release at each check
    add(0,  1'b0, 1'b0, '0, e_apply(2'd0, BOOT), "boot_apply_e0");
    add(3,  1'b0, 1'b0, '0, e_apply(2'd0, BOOT), "boot_apply_e3");
    add(1,  1'b0, 1'b0, '0, e_wait(2'd0, BOOT),  "boot_wait_e4");
    add(6,  1'b0, 1'b0, '0, e_wait(2'd0, BOOT),  "boot_wait_e10");
    add(10, 1'b1, 1'b0, '0, e_wait(2'd0, BOOT),  "boot_stable_e20");
    add(1,  1'b1, 1'b0, '0, e_run(BOOT),         "boot_run_e21");
    add(1,  1'b0, 1'b1, M1, e_apply(2'd0, M1),   "mode_accept_e22");
    add(4,  1'b0, 1'b0, '0, e_wait(2'd0, M1),    "mode_wait_e26");
    add(1,  1'b1, 1'b0, '0, e_wait(2'd0, M1),    "mode_lock_rise_e27");
    add(9,  1'b1, 1'b0, '0, e_wait(2'd0, M1),    "mode_stable_e36");
    add(1,  1'b1, 1'b0, '0, e_run(M1),           "mode_run_e37");
    add(1,  1'b0, 1'b0, '0, e_run(M1),           "loss_sync1_e38");
    add(1,  1'b0, 1'b0, '0, e_run(M1),           "loss_sync2_e39");
    add(1,  1'b0, 1'b0, '0, e_apply(2'd1, M1),   "loss_reapply_e40");
    add(4,  1'b0, 1'b0, '0, e_wait(2'd1, M1),    "to1_wait_e44");
    add(63, 1'b0, 1'b0, '0, e_wait(2'd1, M1),    "to1_last_e107");
    add(1,  1'b0, 1'b0, '0, e_apply(2'd2, M1),   "to1_reapply_e108");
    add(67, 1'b0, 1'b0, '0, e_wait(2'd2, M1),    "to2_last_e175");
    add(1,  1'b0, 1'b0, '0, e_fail(2'd2, M1),    "fail_e176");
    add(1,  1'b0, 1'b1, M2, e_apply(2'd0, M2),   "fail_accept_e177");
    add(4,  1'b0, 1'b0, '0, e_wait(2'd0, M2),    "m2_wait_e181");

    resetn   = 1'b0;
    pll_lock = 1'b0;
    drive_req(1'b0, 18'd0);
    repeat (3) tick();
    resetn = 1'b1;

    foreach (vq[i]) begin
      pll_lock = vq[i].lock;
      drive_req(vq[i].valid, vq[i].codes);
      repeat (vq[i].adv) tick();
      check(vq[i].name, vq[i].exp);
    end
    drive_req(1'b0, 18'd0);

    // Asynchronous reset while in WAIT_LOCK with non-boot codes
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", e_apply(2'd0, BOOT));
    tick();
    resetn = 1'b1;

    // Lock never arrives from boot: three apply passes then FAIL
    for (int p = 0; p < 3; p++) begin
      check($sformatf("to_pass%0d_apply", p), e_apply(2'(p), BOOT));
      repeat (4) tick();
      check($sformatf("to_pass%0d_wait", p), e_wait(2'(p), BOOT));
      repeat (64) tick();
    end
    check("to_fail", e_fail(2'd2, BOOT));
    repeat (5) tick();
    check("to_fail_sticky", e_fail(2'd2, BOOT));

    // One-cycle lock glitch at stable count 5 restarts qualification
    do_reset();
    repeat (4) tick();
    pll_lock = 1'b1;
    repeat (6) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (4) tick();
    check("glitch_no_early_lock_e15", e_wait(2'd0, BOOT));
    repeat (6) tick();
    check("glitch_still_stable_e21", e_wait(2'd0, BOOT));
    tick();
    check("glitch_run_e22", e_run(BOOT));

    // Request in the same cycle the synced lock falls: request wins
    pll_lock = 1'b0;
    repeat (2) tick();
    check("race_still_run", e_run(BOOT));
    drive_req(1'b1, M1);
    tick();
    check("race_req_wins", e_apply(2'd0, M1));
    drive_req(1'b0, 18'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
